// File: rtl/logo_glyph_scroller.sv
// Paints a row of 3x5-cell bitmap glyphs that scrolls horizontally once per frame.
// The scroll either bounces with a hold at each end, or wraps back to zero.
module logo_glyph_scroller #(
  parameter int CHARS       = 4,
  parameter int CELL_LOG2   = 3,
  parameter int X0          = 500,
  parameter int Y0          = 550,
  parameter int STEP        = 2,
  parameter int RANGE       = 100,
  parameter int HOLD_FRAMES = 30,
  parameter int MODE        = 0,
  parameter logic [CHARS*15-1:0] GLYPHS = '1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_start,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        hit,
  output logic [10:0] delt,
  output logic [2:0]  state
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [127:0] GLYPH_PAD = 128'(GLYPHS);

  typedef enum logic [2:0] {
    MOVE_R = 3'd0,
    HOLD_R = 3'd1,
    MOVE_L = 3'd2,
    HOLD_L = 3'd3,
    IDLE   = 3'd4
  } state_t;

  state_t        state_q, state_n;
  logic [10:0]   delt_q, delt_n;
  logic [HW-1:0] hold_q, hold_n;
  logic [11:0]   up;

  logic [11:0] rel_x, rel_y, ccol_w, crow_w, char_w;
  logic        in_range;
  logic [2:0]  s1_char, s1_crow;
  logic [1:0]  s1_col;
  logic        s1_inr, s1_en;
  logic [6:0]  gidx;

  // 12-bit sum so the end-of-range comparison never sees a wrapped value
  assign up = {1'b0, delt_q} + 12'(STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MOVE_R;
      delt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_n;
      delt_q  <= delt_n;
      hold_q  <= hold_n;
    end
  end

  always_comb begin
    state_n = state_q;
    delt_n  = delt_q;
    hold_n  = hold_q;
    if (!enable) begin
      state_n = IDLE;
      delt_n  = '0;
      hold_n  = '0;
    end else if (state_q == IDLE) begin
      state_n = MOVE_R;
    end else if (frame_start) begin
      case (state_q)
        MOVE_R: begin
          if (MODE == 0) begin
            if (up >= 12'(RANGE)) begin
              delt_n  = 11'(RANGE);
              hold_n  = HW'(HOLD_FRAMES - 1);
              state_n = HOLD_R;
            end else begin
              delt_n = up[10:0];
            end
          end else begin
            delt_n = (up > 12'(RANGE)) ? 11'd0 : up[10:0];
          end
        end
        HOLD_R: begin
          if (hold_q == '0) begin
            state_n = MOVE_L;
            delt_n  = delt_q - 11'(STEP);
          end else begin
            hold_n = hold_q - 1'b1;
          end
        end
        MOVE_L: begin
          if ({1'b0, delt_q} <= 12'(STEP)) begin
            delt_n  = '0;
            hold_n  = HW'(HOLD_FRAMES - 1);
            state_n = HOLD_L;
          end else begin
            delt_n = delt_q - 11'(STEP);
          end
        end
        HOLD_L: begin
          if (hold_q == '0) begin
            state_n = MOVE_R;
            delt_n  = up[10:0];
          end else begin
            hold_n = hold_q - 1'b1;
          end
        end
        default: state_n = MOVE_R;
      endcase
    end
  end

  // Column 3 of every glyph is the inter-glyph gap and is never lit
  always_comb begin
    rel_x    = {1'b0, x} - (12'(X0) + {1'b0, delt_q});
    rel_y    = {1'b0, y} - 12'(Y0);
    ccol_w   = rel_x >> CELL_LOG2;
    crow_w   = rel_y >> CELL_LOG2;
    char_w   = ccol_w >> 2;
    in_range = !rel_x[11] && !rel_y[11] && (char_w < 12'(CHARS)) &&
               (ccol_w[1:0] != 2'd3) && (crow_w <= 12'd4);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_char <= '0;
      s1_col  <= '0;
      s1_crow <= '0;
      s1_inr  <= 1'b0;
      s1_en   <= 1'b0;
    end else begin
      s1_char <= char_w[2:0];
      s1_col  <= ccol_w[1:0];
      s1_crow <= crow_w[2:0];
      s1_inr  <= in_range;
      s1_en   <= enable;
    end
  end

  assign gidx = 7'(s1_char) * 7'd15 + 7'(s1_crow) * 7'd3 + 7'(s1_col);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit <= 1'b0;
    end else begin
      hit <= s1_en && s1_inr && GLYPH_PAD[gidx];
    end
  end

  assign delt  = delt_q;
  assign state = state_q;

endmodule

// File: tb/tb_logo_glyph_scroller.sv
// Randomised bench for logo_glyph_scroller: three instances (default bounce, single-bit glyph,
// wrap mode) share one stimulus stream and are scored against a trajectory/geometry model.
module tb_logo_glyph_scroller;

  localparam int STEP_P  = 2;
  localparam int RANGE_P = 100;
  localparam int HOLD_P  = 30;
  localparam int TLEN    = 512;
  localparam logic [59:0] GLY_ALL = '1;
  localparam logic [59:0] GLY_ONE = 60'd16;
  localparam logic [2:0] S_MOVE_R = 3'd0, S_HOLD_R = 3'd1, S_MOVE_L = 3'd2,
                         S_HOLD_L = 3'd3, S_IDLE = 3'd4;

  logic        clk = 1'b0, rst = 1'b0, enable = 1'b1, frame_start = 1'b0;
  logic [10:0] x = '0, y = '0;
  logic        hit_a, hit_b, hit_c;
  logic [10:0] delt_a, delt_b, delt_c;
  logic [2:0]  state_a, state_b, state_c;

  always #5 clk = ~clk;

  logo_glyph_scroller dut_a (.clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
    .x(x), .y(y), .hit(hit_a), .delt(delt_a), .state(state_a));
  logo_glyph_scroller #(.GLYPHS(GLY_ONE)) dut_b (.clk(clk), .rst(rst), .enable(enable),
    .frame_start(frame_start), .x(x), .y(y), .hit(hit_b), .delt(delt_b), .state(state_b));
  logo_glyph_scroller #(.MODE(1)) dut_c (.clk(clk), .rst(rst), .enable(enable),
    .frame_start(frame_start), .x(x), .y(y), .hit(hit_c), .delt(delt_c), .state(state_c));

  int          n_checks = 0, n_fails = 0;
  int          traj_d[TLEN];
  logic [2:0]  traj_s[TLEN];
  int          tn;
  int          bidx, widx;
  logic        m_idle;
  logic [2:0]  e1, e2;

  task automatic checkOutput(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push(input int d, input logic [2:0] s);
    if (tn < TLEN) begin
      traj_d[tn] = d;
      traj_s[tn] = s;
    end
    tn++;
  endtask

  // Bounce trajectory as phases: climb, hold at RANGE, descend, hold at 0, repeat
  task automatic buildTrajectory();
    int d;
    tn = 0;
    d  = 0;
    push(0, S_MOVE_R);
    while (tn < TLEN) begin
      while (d + STEP_P < RANGE_P) begin
        d += STEP_P;
        push(d, S_MOVE_R);
      end
      d = RANGE_P;
      repeat (HOLD_P) push(d, S_HOLD_R);
      d = RANGE_P - STEP_P;
      push(d, S_MOVE_L);
      while (d > STEP_P) begin
        d -= STEP_P;
        push(d, S_MOVE_L);
      end
      d = 0;
      repeat (HOLD_P) push(d, S_HOLD_L);
      d = STEP_P;
      push(d, S_MOVE_R);
    end
  endtask

  function automatic int b_delt();
    return m_idle ? 0 : traj_d[bidx];
  endfunction
  function automatic int b_state();
    return m_idle ? int'(S_IDLE) : int'(traj_s[bidx]);
  endfunction
  function automatic int w_delt();
    return m_idle ? 0 : (widx % (RANGE_P / STEP_P + 1)) * STEP_P;
  endfunction
  function automatic int w_state();
    return m_idle ? int'(S_IDLE) : int'(S_MOVE_R);
  endfunction

  function automatic logic pix_hit(input int px, input int py, input int d, input logic [59:0] g);
    int rx, ry, cx, ch, col, row;
    rx = px - (500 + d);
    ry = py - 550;
    if (rx < 0 || ry < 0) return 1'b0;
    cx  = rx / 8;
    ch  = cx / 4;
    col = cx % 4;
    row = ry / 8;
    if (ch >= 4 || col > 2 || row > 4) return 1'b0;
    return g[ch * 15 + row * 3 + col];
  endfunction

  task automatic checkReset();
    checkOutput("rst_hit_a", hit_a, 0);
    checkOutput("rst_hit_b", hit_b, 0);
    checkOutput("rst_hit_c", hit_c, 0);
    checkOutput("rst_delt_a", delt_a, 0);
    checkOutput("rst_delt_c", delt_c, 0);
    checkOutput("rst_state_a", state_a, S_MOVE_R);
    checkOutput("rst_state_c", state_c, S_MOVE_R);
  endtask

  task automatic doReset();
    rst = 1'b0;
    frame_start = 1'b0;
    enable = 1'b1;
    x = '0;
    y = '0;
    #1;
    checkReset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bidx = 0;
    widx = 0;
    m_idle = 1'b0;
    e1 = '0;
    e2 = '0;
  endtask

  // One cycle: score outputs from earlier cycles, then drive the next pixel and advance the model
  task automatic applyStimulus(input logic fs, input logic en, input int px, input int py);
    logic [2:0] nexp;
    @(negedge clk);
    checkOutput("hit_a", hit_a, e2[0]);
    checkOutput("hit_b", hit_b, e2[1]);
    checkOutput("hit_c", hit_c, e2[2]);
    checkOutput("delt_a", delt_a, b_delt());
    checkOutput("delt_b", delt_b, b_delt());
    checkOutput("delt_c", delt_c, w_delt());
    checkOutput("state_a", state_a, b_state());
    checkOutput("state_c", state_c, w_state());
    frame_start = fs;
    enable = en;
    x = 11'(px);
    y = 11'(py);
    nexp[0] = en && pix_hit(px, py, b_delt(), GLY_ALL);
    nexp[1] = en && pix_hit(px, py, b_delt(), GLY_ONE);
    nexp[2] = en && pix_hit(px, py, w_delt(), GLY_ALL);
    e2 = e1;
    e1 = nexp;
    if (!en) begin
      m_idle = 1'b1;
      bidx = 0;
      widx = 0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (fs) begin
      if (bidx < TLEN - 1) bidx++;
      widx++;
    end
  endtask

  task automatic runFrame(input logic en);
    applyStimulus(1'b1, en, 470 + int'($urandom_range(0, 200)), 540 + int'($urandom_range(0, 50)));
    applyStimulus(1'b0, en, 600, 550);
    applyStimulus(1'b0, en, 470 + int'($urandom_range(0, 200)), 540 + int'($urandom_range(0, 50)));
  endtask

  initial begin
    int found;
    buildTrajectory();
    doReset();

    applyStimulus(1'b0, 1'b1, 500, 550);
    applyStimulus(1'b0, 1'b1, 524, 550);
    applyStimulus(1'b0, 1'b1, 499, 550);
    applyStimulus(1'b0, 1'b1, 508, 558);
    applyStimulus(1'b0, 1'b1, 540, 550);
    applyStimulus(1'b0, 1'b1, 600, 550);
    applyStimulus(1'b0, 1'b1, 0, 0);
    applyStimulus(1'b0, 1'b1, 0, 0);

    repeat (3) runFrame(1'b1);
    checkOutput("pulse3_delt", delt_a, 6);
    repeat (77) runFrame(1'b1);
    checkOutput("pulse80_delt", delt_a, 98);
    checkOutput("pulse80_state", state_a, S_MOVE_L);
    repeat (29) runFrame(1'b1);
    checkOutput("pulse109_delt", delt_a, 40);

    applyStimulus(1'b1, 1'b0, 500, 550);
    repeat (3) applyStimulus(1'b0, 1'b0, 500, 550);
    repeat (2) applyStimulus(1'b0, 1'b1, 500, 550);
    runFrame(1'b1);
    checkOutput("reenable_delt", delt_a, 2);

    for (int i = 0; i < 60; i++) runFrame($urandom_range(0, 7) != 0);

    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      runFrame(1'b1);
      if (state_a == S_HOLD_R) found = 1;
    end
    checkOutput("reach_hold_r", found, 1);

    @(negedge clk);
    #2;
    doReset();
    repeat (5) runFrame(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/logo_glyph_scroller.md
# logo_glyph_scroller

Parametrised, clocked successor to the fixed-rectangle logo painters in the VGA path. Renders a row of `CHARS` glyphs from a 3×5-cell bitmap parameter. Scrolls the row horizontally once per frame, in either a bounce (with hold) or a wrap mode. Returns a registered per-pixel `hit` to the VGA colour mux, 2 cycles after the pixel coordinates.

## Interface
Parameters:
- `CHARS`, 4, number of glyphs (1..8).
- `CELL_LOG2`, 3, log2 of cell size in pixels (cell = 8×8 px).
- `X0`, 500, left edge of glyph 0 at offset 0.
- `Y0`, 550, top edge of the glyph row.
- `STEP`, 2, pixels moved per frame (≥1).
- `RANGE`, 100, maximum offset (≥ `STEP`, < 2048).
- `HOLD_FRAMES`, 30, frames held at each end in bounce mode (≥1).
- `MODE`, 0, 0 = bounce, 1 = wrap.
- `GLYPHS`, all-ones `CHARS*15` bits, glyph bitmaps. Bit `c*15 + row*3 + col` is char `c`, row 0..4, col 0..2, where bit 0 is the top-left of char 0.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-low reset.
- `enable` in 1: painter enable.
- `frame_start` in 1: one-cycle pulse per frame.
- `x` in 11: current pixel column.
- `y` in 11: current pixel row.
- `hit` out 1: pixel belongs to a lit glyph cell (registered).
- `delt` out 11: current scroll offset.
- `state` out 3: scroll FSM state, for debug.

## Operation
- **Geometry.** Left edge = `X0 + delt`. Compute `rel_x = x − (X0+delt)` and `rel_y = y − Y0` at 12-bit signed width.
  - Either value negative → no hit.
  - `ccol = rel_x >> CELL_LOG2`, `crow = rel_y >> CELL_LOG2`.
  - `char = ccol >> 2`, `col = ccol[1:0]`. Column 3 is the inter-glyph gap and is never lit.
  - Hit requires `char < CHARS`, `col ≤ 2`, `crow ≤ 4`, and the addressed `GLYPHS` bit set.
- **Scroll FSM.** States: `MOVE_R`, `HOLD_R`, `MOVE_L`, `HOLD_L`, `IDLE`. Transitions are evaluated only on `frame_start`, except where noted.
  - `MOVE_R`:
    - Bounce mode: if `delt + STEP ≥ RANGE`, set `delt = RANGE`, load `hold_cnt = HOLD_FRAMES−1`, go to `HOLD_R`. Otherwise `delt += STEP`.
    - Wrap mode: if `delt + STEP > RANGE`, set `delt = 0`. Otherwise `delt += STEP`. Wrap mode never leaves `MOVE_R`.
  - `HOLD_R`: if `hold_cnt == 0`, go to `MOVE_L` and apply `delt −= STEP` in the same frame. Otherwise decrement `hold_cnt`.
  - `MOVE_L`: if `delt ≤ STEP`, set `delt = 0`, load `hold_cnt = HOLD_FRAMES−1`, go to `HOLD_L`. Otherwise `delt −= STEP`.
  - `HOLD_L`: mirror of `HOLD_R`. Exits to `MOVE_R` with `delt += STEP`.
  - `IDLE`: entered on any cycle with `enable = 0`, independent of `frame_start`. `delt` is cleared to 0. On the first cycle with `enable = 1`, go to `MOVE_R`.
- **Arithmetic widths.**
  - Offset arithmetic uses 12 bits, so `delt + STEP` cannot overflow before the comparison.
  - `hold_cnt` is wide enough for `HOLD_FRAMES−1`.
- **Simultaneous events.** `enable = 0` with `frame_start = 1` → `enable` wins: `IDLE`, `delt = 0`.

## Timing
- **Reset values** (`rst` low, asynchronous): `hit = 0`, `delt = 0`, `state = MOVE_R`, `hold_cnt = 0`, pipeline registers cleared. Reset mid-frame or mid-hold aborts immediately.
- **Pixel pipeline, 2 stages.**
  - Stage 1 registers `rel_x`/`rel_y`-derived `char`, `col`, `crow` and an in-range flag.
  - Stage 2 registers `hit`.
  - `hit` at cycle n+2 reflects `x`/`y` sampled at n.
- **Offset snapshot.** Stage 1 uses `delt` as it stands at its sampling edge. A `delt` update on `frame_start` affects pixels sampled on the following cycle onward.
- **Enable gating.** `hit` is forced to 0 at stage 2 whenever stage 1 was captured with `enable = 0`.
- **Throughput.** One pixel per clock, no stalls.

## Test plan
- **Reset and first pixel.** Defaults; release reset; `enable = 1`, `x = 500`, `y = 550` → `hit = 1` exactly 2 cycles later. `x = 524` (gap column) → `hit = 0`. `x = 499` → `hit = 0`.
- **Glyph lookup.** Set `GLYPHS` bit 4 (char 0, row 1, col 1) only. `x = 508`, `y = 558` → `hit = 1`. `x = 500`, `y = 550` → 0. `x = 540` (char 1) → 0.
- **Bounce trajectory.**
  - After 3 `frame_start` pulses: `delt = 6`.
  - At pulse 50: `delt = 100`, `state = HOLD_R`.
  - `delt` stays 100 through pulse 79.
  - Pulse 80: `delt = 98`, `MOVE_L`.
  - Pixel `x = 600`, `y = 550` hits while `delt = 100`.
- **Wrap mode.** `MODE = 1`: pulse 50 → `delt = 100`; pulse 51 → `delt = 0`; state is always `MOVE_R`.
- **Enable drop.** `enable = 0` coincident with `frame_start` at `delt = 40` → next cycle `delt = 0`, `IDLE`, `hit = 0` from 2 cycles later. Re-enable → `MOVE_R`; next pulse → `delt = 2`.
- **Asynchronous reset.** Assert `rst` low mid-`HOLD_R` between clock edges → `delt = 0`, `hit = 0`, `state = MOVE_R` immediately, without waiting for a clock edge.
